// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming SECDED codec: width helpers, encoder,
// syndrome and data extraction functions, and the decode result record.
// The functions work on maximum-width vectors so one definition serves every P
// up to MAX_P. Bits above the active code width are kept at zero.
package hamming_pkg;

   localparam int MAX_P = 6;
   localparam int MAX_N = 1 << MAX_P;
   localparam int MAX_K = MAX_N - MAX_P - 1;

   typedef struct packed {
      logic [MAX_K-1:0] data;
      logic [MAX_P-1:0] syndrome;
      logic             corrected;
      logic             uncorrectable;
   } decode_t;

   function automatic int data_w(input int p);
      return (1 << p) - p - 1;
   endfunction

   function automatic int code_w(input int p);
      return 1 << p;
   endfunction

   function automatic logic is_pow2(input int pos);
      return (pos != 0) && ((pos & (pos - 1)) == 0);
   endfunction

   // Data bits go into the non-power-of-two positions in ascending order.
   // Parity j covers every position with bit j set. Position 0 holds the
   // overall parity of the whole word.
   function automatic logic [MAX_N-1:0] hamming_encode(input int p, input logic [MAX_K-1:0] d);
      logic [MAX_N-1:0] cw;
      logic             par;
      int               k;
      cw = '0;
      k  = 0;
      for (int pos = 1; pos < MAX_N; pos++) begin
         if (pos < code_w(p) && !is_pow2(pos)) begin
            cw[pos] = d[k];
            k       = k + 1;
         end
      end
      for (int j = 0; j < MAX_P; j++) begin
         if (j < p) begin
            par = 1'b0;
            for (int pos = 1; pos < MAX_N; pos++) begin
               if (pos < code_w(p) && pos[j]) begin
                  par = par ^ cw[pos];
               end
            end
            cw[1 << j] = par;
         end
      end
      cw[0] = ^cw;
      return cw;
   endfunction

   // The syndrome is the XOR of the indices of all set bits, excluding position 0.
   function automatic logic [MAX_P-1:0] syndrome(input int p, input logic [MAX_N-1:0] cw);
      logic [MAX_P-1:0] s;
      s = '0;
      for (int pos = 1; pos < MAX_N; pos++) begin
         if (pos < code_w(p) && cw[pos]) begin
            s = s ^ pos[MAX_P-1:0];
         end
      end
      return s;
   endfunction

   // Collects the data positions back into a packed data word.
   function automatic logic [MAX_K-1:0] extract_data(input int p, input logic [MAX_N-1:0] cw);
      logic [MAX_K-1:0] d;
      int               k;
      d = '0;
      k = 0;
      for (int pos = 1; pos < MAX_N; pos++) begin
         if (pos < code_w(p) && !is_pow2(pos)) begin
            d[k] = cw[pos];
            k    = k + 1;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/hamming_secded_pipe_if.sv
// Input and output streams of the SECDED pipe. The master drives words in and
// accepts words out. The slave is the codec.
interface hamming_secded_pipe_if import hamming_pkg::*; #(parameter int P = 3);
   localparam int K = data_w(P);
   localparam int N = code_w(P);

   logic [K-1:0] in_data;
   logic [N-1:0] in_err;
   logic         in_valid;
   logic         in_ready;
   logic [K-1:0] out_data;
   logic         out_valid;
   logic         out_ready;
   logic [P-1:0] out_syndrome;
   logic         out_corrected;
   logic         out_uncorrectable;

   modport master (
      output in_data, in_err, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_syndrome, out_corrected, out_uncorrectable
   );

   modport slave (
      input  in_data, in_err, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_syndrome, out_corrected, out_uncorrectable
   );
endinterface

// File: rtl/hamming_secded_decoder.sv
// Combinational SECDED decoder. An odd overall parity marks a single error at
// position s, where s = 0 means the overall parity bit itself. An even overall
// parity with a nonzero syndrome marks a double error. For a double error the
// data is passed through uncorrected.
module hamming_secded_decoder import hamming_pkg::*; #(
   parameter  int P = 3,
   localparam int K = data_w(P),
   localparam int N = code_w(P)
) (
   input  logic [N-1:0] rx,
   output logic [K-1:0] data,
   output logic [P-1:0] syn,
   output logic         corrected,
   output logic         uncorrectable
);

   logic [MAX_N-1:0] rx_ext_s;
   logic [MAX_N-1:0] fixed_s;
   logic [MAX_P-1:0] syn_full_s;
   logic [MAX_K-1:0] data_full_s;

   // Compute the syndrome and overall parity, flip the bit in error, and extract the data.
   always_comb begin
      rx_ext_s         = '0;
      rx_ext_s[N-1:0]  = rx;
      syn_full_s       = syndrome(P, rx_ext_s);
      fixed_s          = rx_ext_s;
      corrected        = 1'b0;
      uncorrectable    = 1'b0;
      if (^rx) begin
         fixed_s[syn_full_s] = ~fixed_s[syn_full_s];
         corrected           = 1'b1;
      end else if (syn_full_s != '0) begin
         uncorrectable = 1'b1;
      end else begin
         corrected = 1'b0;
      end
      data_full_s = extract_data(P, fixed_s);
      data        = data_full_s[K-1:0];
      syn         = syn_full_s[P-1:0];
   end

endmodule

// File: rtl/hamming_secded_pipe.sv
// Two-stage SECDED link. Stage 1 registers the encoded word with the injected
// errors. Stage 2 registers the decoded result. Each stage loads whenever the
// next stage is empty or draining. Saturating counters track corrected and
// uncorrectable words at the output handshake.
module hamming_secded_pipe import hamming_pkg::*; #(
   parameter  int P     = 3,
   parameter  int CNT_W = 16,
   localparam int K     = data_w(P),
   localparam int N     = code_w(P)
) (
   input  logic                  clk,
   input  logic                  rst,
   hamming_secded_pipe_if.slave  bus,
   input  logic                  clear_counts,
   output logic [CNT_W-1:0]      corr_count,
   output logic [CNT_W-1:0]      uncorr_count
);

   logic             s1_valid_r;
   logic [N-1:0]     s1_rx_r;
   logic             out_valid_r;
   logic [K-1:0]     out_data_r;
   logic [P-1:0]     out_syn_r;
   logic             out_corr_r;
   logic             out_unc_r;
   logic [CNT_W-1:0] corr_cnt_r;
   logic [CNT_W-1:0] unc_cnt_r;

   logic             s2_load_s;
   logic             s1_advance_s;
   logic             in_ready_s;
   logic             accept_s;
   logic             out_hs_s;
   logic [MAX_K-1:0] in_data_ext_s;
   logic [MAX_N-1:0] enc_full_s;
   logic [K-1:0]     dec_data_s;
   logic [P-1:0]     dec_syn_s;
   logic             dec_corr_s;
   logic             dec_unc_s;

   assign s2_load_s    = !out_valid_r || bus.out_ready;
   assign s1_advance_s = s1_valid_r && s2_load_s;
   assign in_ready_s   = !s1_valid_r || s1_advance_s;
   assign accept_s     = bus.in_valid && in_ready_s;
   assign out_hs_s     = out_valid_r && bus.out_ready;

   // Zero-extend the input data and encode it at the maximum width.
   always_comb begin
      in_data_ext_s         = '0;
      in_data_ext_s[K-1:0]  = bus.in_data;
      enc_full_s            = hamming_encode(P, in_data_ext_s);
   end

   hamming_secded_decoder #(.P(P)) u_decoder (
      .rx            (s1_rx_r),
      .data          (dec_data_s),
      .syn           (dec_syn_s),
      .corrected     (dec_corr_s),
      .uncorrectable (dec_unc_s)
   );

   // Stage 1: capture the encoded word with the errors applied, and hold it while stage 2 is stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_rx_r    <= '0;
      end else if (in_ready_s) begin
         s1_valid_r <= bus.in_valid;
         if (accept_s) begin
            s1_rx_r <= enc_full_s[N-1:0] ^ bus.in_err;
         end else begin
            s1_rx_r <= s1_rx_r;
         end
      end else begin
         s1_valid_r <= s1_valid_r;
      end
   end

   // Stage 2: register the decode result. All outputs hold until the handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_syn_r   <= '0;
         out_corr_r  <= 1'b0;
         out_unc_r   <= 1'b0;
      end else if (s2_load_s) begin
         out_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            out_data_r <= dec_data_s;
            out_syn_r  <= dec_syn_s;
            out_corr_r <= dec_corr_s;
            out_unc_r  <= dec_unc_s;
         end else begin
            out_data_r <= out_data_r;
         end
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   // Saturating error counters. A clear takes priority over an increment in the same cycle.
   always_ff @(posedge clk) begin
      if (rst || clear_counts) begin
         corr_cnt_r <= '0;
         unc_cnt_r  <= '0;
      end else if (out_hs_s) begin
         if (out_corr_r && !(&corr_cnt_r)) begin
            corr_cnt_r <= corr_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            corr_cnt_r <= corr_cnt_r;
         end
         if (out_unc_r && !(&unc_cnt_r)) begin
            unc_cnt_r <= unc_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            unc_cnt_r <= unc_cnt_r;
         end
      end else begin
         corr_cnt_r <= corr_cnt_r;
      end
   end

   assign bus.in_ready          = in_ready_s;
   assign bus.out_valid         = out_valid_r;
   assign bus.out_data          = out_data_r;
   assign bus.out_syndrome      = out_syn_r;
   assign bus.out_corrected     = out_corr_r;
   assign bus.out_uncorrectable = out_unc_r;
   assign corr_count            = corr_cnt_r;
   assign uncorr_count          = unc_cnt_r;

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// Bench for hamming_secded_pipe (P=3), with a second instance at CNT_W=2 for
// the saturation test. The reference model predicts outputs from the error
// vector: weight 1 is corrected, weight 2 is uncorrectable, and the syndrome is
// the XOR of the flipped positions.
module tb_hamming_secded_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clear_counts = 1'b0;
   logic clear2 = 1'b0;
   logic [15:0] corr_count, uncorr_count;
   logic [1:0]  corr2, uncorr2;

   int checks = 0;
   int failures = 0;
   int exp_cc = 0;
   int exp_uc = 0;

   hamming_secded_pipe_if #(.P(3)) bus ();
   hamming_secded_pipe_if #(.P(3)) bus2 ();

   hamming_secded_pipe #(.P(3), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave), .clear_counts(clear_counts),
      .corr_count(corr_count), .uncorr_count(uncorr_count)
   );

   hamming_secded_pipe #(.P(3), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2.slave), .clear_counts(clear2),
      .corr_count(corr2), .uncorr_count(uncorr2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] data;
      logic [2:0] syn;
      logic       corr;
      logic       unc;
   } exp_t;

   typedef struct {
      logic [3:0] data;
      logic [7:0] err;
      logic [3:0] e_data;
      logic [2:0] e_syn;
      logic       e_corr;
      logic       e_unc;
      int         e_cc;
      int         e_uc;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] ref_encode(input logic [3:0] d);
      logic [7:0] cw;
      logic       par;
      cw = 8'h00;
      cw[3] = d[0]; cw[5] = d[1]; cw[6] = d[2]; cw[7] = d[3];
      for (int j = 0; j < 3; j++) begin
         par = 1'b0;
         for (int pos = 1; pos < 8; pos++) if (((pos >> j) & 1) == 1) par ^= cw[pos];
         cw[1 << j] = par;
      end
      cw[0] = ^cw;
      return cw;
   endfunction

   function automatic exp_t ref_model(input logic [3:0] d, input logic [7:0] e);
      exp_t       r;
      logic [7:0] rx;
      int         w;
      w  = $countones(e);
      rx = ref_encode(d) ^ e;
      r.syn = 3'd0;
      for (int pos = 0; pos < 8; pos++) if (e[pos]) r.syn ^= 3'(pos);
      r.corr = (w == 1);
      r.unc  = (w == 2);
      r.data = (w == 2) ? {rx[7], rx[6], rx[5], rx[3]} : d;
      return r;
   endfunction

   function automatic logic [7:0] rand_err();
      logic [7:0] e;
      int         w;
      w = $urandom_range(0, 2);
      e = 8'h00;
      while ($countones(e) < w) e[$urandom_range(0, 7)] = 1'b1;
      return e;
   endfunction

   // Streams n words, with out_ready toggling (mode 0) or random (mode 1), and
   // scoreboards the output order, the field values, stability while stalled,
   // and in_ready.
   task automatic run_stream(input int n, input int mode);
      exp_t       q[$];
      exp_t       pend, got_e;
      int         sent = 0, got = 0, cyc = 0, inflight = 0;
      logic       acc_last = 1'b0, acc, hs, stalled_prev = 1'b0;
      logic [3:0] d;
      logic [7:0] e;
      logic [9:0] snap = 10'h0;
      while (got < n && cyc < 2000) begin
         @(negedge clk);
         if (stalled_prev) begin
            check("stall_valid", bus.out_valid, 1'b1);
            check("stall_hold", {bus.out_data, bus.out_syndrome, bus.out_corrected, bus.out_uncorrectable}, snap);
         end
         bus.out_ready = (mode == 0) ? ((cyc % 2) == 0) : ($urandom_range(0, 3) != 0);
         if (acc_last) bus.in_valid = 1'b0;
         if (!bus.in_valid && sent < n && (mode == 0 || $urandom_range(0, 3) != 0)) begin
            d = 4'($urandom_range(0, 15));
            e = rand_err();
            pend = ref_model(d, e);
            bus.in_data = d;
            bus.in_err = e;
            bus.in_valid = 1'b1;
         end
         #1;
         check("in_ready", bus.in_ready, !(inflight == 2 && !bus.out_ready));
         acc = bus.in_valid && bus.in_ready;
         hs  = bus.out_valid && bus.out_ready;
         if (hs) begin
            if (q.size() == 0) begin
               check("spurious_out", 1'b1, 1'b0);
            end else begin
               got_e = q.pop_front();
               check("str_data", bus.out_data, got_e.data);
               check("str_syn", bus.out_syndrome, got_e.syn);
               check("str_corr", bus.out_corrected, got_e.corr);
               check("str_unc", bus.out_uncorrectable, got_e.unc);
               if (got_e.corr) exp_cc++;
               if (got_e.unc) exp_uc++;
            end
            got++;
            inflight--;
         end
         if (acc) begin
            q.push_back(pend);
            sent++;
            inflight++;
         end
         stalled_prev = bus.out_valid && !bus.out_ready;
         snap = {bus.out_data, bus.out_syndrome, bus.out_corrected, bus.out_uncorrectable};
         acc_last = acc;
         cyc++;
         @(posedge clk);
      end
      if (got < n) check("stream_timeout", got, n);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      check("str_corr_count", corr_count, exp_cc);
      check("str_uncorr_count", uncorr_count, exp_uc);
   endtask

   vec_t vecs[6];
   int   waited;

   initial begin
      vecs[0] = '{4'hB, 8'h00, 4'hB, 3'd0, 1'b0, 1'b0, 0, 0};
      vecs[1] = '{4'hB, 8'h20, 4'hB, 3'd5, 1'b1, 1'b0, 1, 0};
      vecs[2] = '{4'hB, 8'h01, 4'hB, 3'd0, 1'b1, 1'b0, 2, 0};
      vecs[3] = '{4'hB, 8'h0C, 4'hA, 3'd1, 1'b0, 1'b1, 2, 1};
      vecs[4] = '{4'h0, 8'h80, 4'h0, 3'd7, 1'b1, 1'b0, 3, 1};
      vecs[5] = '{4'hF, 8'h03, 4'hF, 3'd1, 1'b0, 1'b1, 3, 2};

      bus.in_data = 4'h0; bus.in_err = 8'h00; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      bus2.in_data = 4'h0; bus2.in_err = 8'h00; bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_out_data", bus.out_data, 4'h0);
      check("rst_flags", {bus.out_syndrome, bus.out_corrected, bus.out_uncorrectable}, 5'h0);
      check("rst_counts", {corr_count, uncorr_count}, 32'h0);
      check("rst_counts2", {corr2, uncorr2}, 4'h0);

      // Directed vectors, one word at a time, with 2-cycle latency checks.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.in_data = vecs[i].data; bus.in_err = vecs[i].err; bus.in_valid = 1'b1;
         @(posedge clk); @(negedge clk);
         bus.in_valid = 1'b0;
         check("vec_lat1_valid", bus.out_valid, 1'b0);
         @(posedge clk); @(negedge clk);
         check("vec_lat2_valid", bus.out_valid, 1'b1);
         check("vec_data", bus.out_data, vecs[i].e_data);
         check("vec_syn", bus.out_syndrome, vecs[i].e_syn);
         check("vec_corr", bus.out_corrected, vecs[i].e_corr);
         check("vec_unc", bus.out_uncorrectable, vecs[i].e_unc);
         @(posedge clk); @(negedge clk);
         check("vec_corr_count", corr_count, vecs[i].e_cc);
         check("vec_uncorr_count", uncorr_count, vecs[i].e_uc);
      end
      exp_cc = 3; exp_uc = 2;

      // Eight words with out_ready alternating, then a longer random stream.
      run_stream(8, 0);
      run_stream(200, 1);

      // Narrow counters saturate at 3, and a clear beats a same-cycle increment.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus2.in_data = 4'(i); bus2.in_err = 8'h01 << i; bus2.in_valid = 1'b1;
      end
      @(negedge clk);
      bus2.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("sat_corr2", corr2, 2'd3);
      check("sat_uncorr2", uncorr2, 2'd0);
      bus2.in_data = 4'h6; bus2.in_err = 8'h40; bus2.in_valid = 1'b1;
      @(negedge clk);
      bus2.in_valid = 1'b0;
      waited = 0;
      while (!bus2.out_valid && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      check("clr_out_valid", bus2.out_valid, 1'b1);
      check("clr_out_corr", bus2.out_corrected, 1'b1);
      clear2 = 1'b1;
      @(negedge clk);
      clear2 = 1'b0;
      check("clr_corr2", corr2, 2'd0);
      bus2.in_data = 4'h3; bus2.in_err = 8'h08; bus2.in_valid = 1'b1;
      @(negedge clk);
      bus2.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("after_clr_corr2", corr2, 2'd1);

      // Reset with both stages full and the output stalled.
      bus.out_ready = 1'b0;
      bus.in_data = 4'h5; bus.in_err = 8'h02; bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_data = 4'h9; bus.in_err = 8'h10;
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      check("full_in_ready", bus.in_ready, 1'b0);
      check("full_out_valid", bus.out_valid, 1'b1);
      check("pre_rst_count", corr_count, exp_cc);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      check("mid_rst_out_valid", bus.out_valid, 1'b0);
      check("mid_rst_in_ready", bus.in_ready, 1'b1);
      check("mid_rst_counts", {corr_count, uncorr_count}, 32'h0);
      check("mid_rst_out_data", bus.out_data, 4'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_no_out", bus.out_valid, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
